// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/stall/flush pipeline protocol blocks.
package pipe_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int HEAD_FLUSH_LAT = 3;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FLUSH      = 2'd1,
        ST_FLUSH_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_issue_unit_if.sv
// Host request, pipeline head and chain-tail return signals of the issue unit.
interface pipeline_issue_unit_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req_valid;
    logic [DATA_W-1:0] req_data;
    logic              req_ready;
    logic              flush_req;
    logic [DATA_W-1:0] inputs;
    logic              in_valid;
    logic              in_flush;
    logic              out_stall;
    logic              ret_accept;
    logic              ret_flush;
    logic [7:0]        inflight;
    logic              flush_done;
    logic              flush_err;

    // master: the issue unit itself
    modport master (
        input  req_valid, req_data, flush_req, out_stall, ret_accept, ret_flush,
        output req_ready, inputs, in_valid, in_flush, inflight, flush_done, flush_err
    );

    // slave: host plus pipeline chain around the issue unit
    modport slave (
        output req_valid, req_data, flush_req, out_stall, ret_accept, ret_flush,
        input  req_ready, inputs, in_valid, in_flush, inflight, flush_done, flush_err
    );

endinterface

// File: rtl/pipeline_issue_unit_credit.sv
// Saturating up/down credit counter with a below-limit flag; clear has priority.
module issue_credit_counter #(
    parameter int CNT_W = 8,
    parameter int LIMIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             below_limit_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i) begin
            if (count_q != '1) count_d = count_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (count_q != '0) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o       = count_q;
    assign below_limit_o = (count_q < CNT_W'(LIMIT));

endmodule

// File: rtl/pipeline_issue_unit.sv
// Producer end of the pipeline chain: one-entry hold register, credit-capped issue,
// and flush origination that blocks issue until the marker returns or times out.
module pipeline_issue_unit
    import pipe_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int MAX_INFLIGHT  = 8,
    parameter int FLUSH_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_issue_unit_if.master bus
);

    state_e            state_q, state_d;
    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [7:0]        tmo_q, tmo_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        inflight;
    logic              below_limit;
    logic              in_run, in_wait;
    logic              issue, ready, ret_dec, timeout_hit, complete;

    assign in_run  = (state_q == ST_RUN);
    assign in_wait = (state_q == ST_FLUSH_WAIT);

    // flush_req beats both issue and acceptance in the cycle it is seen
    assign issue       = in_run & hold_valid_q & ~bus.out_stall & below_limit & ~bus.flush_req;
    assign ready       = ~reset & in_run & ~bus.flush_req & (~hold_valid_q | issue);
    assign ret_dec     = bus.ret_accept & ~in_wait;
    assign timeout_hit = in_wait & ~bus.ret_flush & (tmo_q >= 8'(FLUSH_TIMEOUT - 1));
    assign complete    = in_wait & (bus.ret_flush | timeout_hit);

    issue_credit_counter #(
        .CNT_W (8),
        .LIMIT (MAX_INFLIGHT)
    ) u_credit (
        .clk           (clk),
        .reset         (reset),
        .inc_i         (issue),
        .dec_i         (ret_dec),
        .clr_i         (complete),
        .count_o       (inflight),
        .below_limit_o (below_limit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:        if (bus.flush_req) state_d = ST_FLUSH;
            ST_FLUSH:      state_d = ST_FLUSH_WAIT;
            ST_FLUSH_WAIT: if (complete) state_d = ST_RUN;
            default:       state_d = ST_RUN;
        endcase
    end

    always_comb begin
        bus.req_ready  = ready;
        bus.in_valid   = issue;
        bus.in_flush   = (state_q == ST_FLUSH);
        bus.inputs     = hold_data_q;
        bus.inflight   = inflight;
        bus.flush_done = done_q;
        bus.flush_err  = err_q;
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        tmo_d        = tmo_q;
        done_d       = complete;
        err_d        = err_q | timeout_hit;
        if (state_q == ST_FLUSH) begin
            hold_valid_d = 1'b0;
            tmo_d        = '0;
        end else if (ready & bus.req_valid) begin
            hold_valid_d = 1'b1;
            hold_data_d  = bus.req_data;
        end else if (issue) begin
            hold_valid_d = 1'b0;
        end
        if (in_wait && !complete && tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            tmo_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            tmo_q        <= tmo_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_pipeline_issue_unit.sv
// Bench for pipeline_issue_unit: two instances (8 and 2 credits) share one stimulus
// stream and are each compared every cycle against a behavioural model.
module tb_pipeline_issue_unit;
    import pipe_pkg::*;

    localparam int DW   = 32;
    localparam int TMO  = 15;
    localparam int NCYC = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          req_valid, flush_req, out_stall, ret_accept, ret_flush;
    logic [DW-1:0] req_data;

    pipeline_issue_unit_if #(.DATA_W(DW)) bus8 ();
    pipeline_issue_unit_if #(.DATA_W(DW)) bus2 ();

    assign bus8.req_valid  = req_valid;  assign bus2.req_valid  = req_valid;
    assign bus8.req_data   = req_data;   assign bus2.req_data   = req_data;
    assign bus8.flush_req  = flush_req;  assign bus2.flush_req  = flush_req;
    assign bus8.out_stall  = out_stall;  assign bus2.out_stall  = out_stall;
    assign bus8.ret_accept = ret_accept; assign bus2.ret_accept = ret_accept;
    assign bus8.ret_flush  = ret_flush;  assign bus2.ret_flush  = ret_flush;

    pipeline_issue_unit #(.DATA_W(DW), .MAX_INFLIGHT(8), .FLUSH_TIMEOUT(TMO)) u_dut8 (
        .clk(clk), .reset(reset), .bus(bus8));
    pipeline_issue_unit #(.DATA_W(DW), .MAX_INFLIGHT(2), .FLUSH_TIMEOUT(TMO)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2));

    // DUT outputs indexed by instance: 0 = 8 credits, 1 = 2 credits
    logic          o_rdy [2], o_val [2], o_fl [2], o_dn [2], o_err [2];
    logic [DW-1:0] o_dat [2];
    logic [7:0]    o_inf [2];
    assign o_rdy[0] = bus8.req_ready;  assign o_rdy[1] = bus2.req_ready;
    assign o_val[0] = bus8.in_valid;   assign o_val[1] = bus2.in_valid;
    assign o_fl[0]  = bus8.in_flush;   assign o_fl[1]  = bus2.in_flush;
    assign o_dn[0]  = bus8.flush_done; assign o_dn[1]  = bus2.flush_done;
    assign o_err[0] = bus8.flush_err;  assign o_err[1] = bus2.flush_err;
    assign o_dat[0] = bus8.inputs;     assign o_dat[1] = bus2.inputs;
    assign o_inf[0] = bus8.inflight;   assign o_inf[1] = bus2.inflight;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model; phase: -1 running, 0 flush cycle, n>=1 = n-th wait cycle
    int            m_max [2] = '{8, 2};
    bit            m_hv [2];
    logic [DW-1:0] m_hd [2];
    int            m_cnt [2];
    int            m_ph [2];
    bit            m_done [2];
    bit            m_err [2];
    bit            e_iss [2];
    bit            e_rdy [2];

    logic          ob_v [2][NCYC], ob_fl [2][NCYC], ob_dn [2][NCYC], ob_err [2][NCYC], ob_rdy [2][NCYC];
    logic [DW-1:0] ob_d [2][NCYC];
    logic [7:0]    ob_inf [2][NCYC];

    int            cyc = 0;
    logic [DW-1:0] hostq [$];
    int            drv = 0;
    bit            rand_mode = 0;
    bit            auto_ret = 0;
    logic [2:0]    rl = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic m_reset(input int k);
        m_hv[k] = 0; m_hd[k] = '0; m_cnt[k] = 0; m_ph[k] = -1; m_done[k] = 0; m_err[k] = 0;
        e_iss[k] = 0; e_rdy[k] = 0;
    endtask

    task automatic eval(input int k);
        bit    run, iss, rdy, dec;
        string sfx;
        sfx = (k == 0) ? "_m8" : "_m2";
        if (reset) begin
            chk({"rst_ready", sfx},    32'(o_rdy[k]), 0);
            chk({"rst_in_valid", sfx}, 32'(o_val[k]), 0);
            chk({"rst_in_flush", sfx}, 32'(o_fl[k]),  0);
            chk({"rst_done", sfx},     32'(o_dn[k]),  0);
            chk({"rst_err", sfx},      32'(o_err[k]), 0);
            chk({"rst_inflight", sfx}, 32'(o_inf[k]), 0);
            chk({"rst_inputs", sfx},   o_dat[k],      0);
            e_iss[k] = 0; e_rdy[k] = 0;
            return;
        end
        run = (m_ph[k] < 0);
        iss = run && m_hv[k] && !out_stall && (m_cnt[k] < m_max[k]) && !flush_req;
        rdy = run && !flush_req && (!m_hv[k] || iss);
        e_iss[k] = iss; e_rdy[k] = rdy;
        chk({"req_ready", sfx},  32'(o_rdy[k]), 32'(rdy));
        chk({"in_valid", sfx},   32'(o_val[k]), 32'(iss));
        chk({"in_flush", sfx},   32'(o_fl[k]),  32'(m_ph[k] == 0));
        chk({"flush_done", sfx}, 32'(o_dn[k]),  32'(m_done[k]));
        chk({"flush_err", sfx},  32'(o_err[k]), 32'(m_err[k]));
        chk({"inflight", sfx},   32'(o_inf[k]), 32'(m_cnt[k]));
        if (iss) chk({"token", sfx}, o_dat[k], m_hd[k]);
        dec = ret_accept && !(m_ph[k] > 0);
        if (iss && !dec) m_cnt[k]++;
        else if (dec && !iss && m_cnt[k] > 0) m_cnt[k]--;
        m_done[k] = 0;
        if (run) begin
            if (flush_req) m_ph[k] = 0;
            if (rdy && req_valid) begin m_hv[k] = 1; m_hd[k] = req_data; end
            else if (iss) m_hv[k] = 0;
        end else if (m_ph[k] == 0) begin
            m_hv[k] = 0; m_ph[k] = 1;
        end else if (ret_flush || m_ph[k] >= TMO) begin
            m_cnt[k] = 0; m_done[k] = 1; m_ph[k] = -1;
            if (!ret_flush) m_err[k] = 1;
        end else begin
            m_ph[k]++;
        end
    endtask

    task automatic set_req();
        req_valid = (hostq.size() != 0) && (!rand_mode || $urandom_range(3) != 0);
        if (hostq.size() != 0) req_data = hostq[0];
    endtask

    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (cyc < NCYC) begin
                ob_v[k][cyc] = o_val[k]; ob_fl[k][cyc] = o_fl[k]; ob_dn[k][cyc] = o_dn[k];
                ob_err[k][cyc] = o_err[k]; ob_rdy[k][cyc] = o_rdy[k];
                ob_d[k][cyc] = o_dat[k]; ob_inf[k][cyc] = o_inf[k];
            end
            eval(k);
        end
        if (req_valid && e_rdy[drv] && hostq.size() != 0) void'(hostq.pop_front());
        rl = {rl[1:0], e_iss[0]};
        @(posedge clk);
        #1;
        cyc++;
        if (auto_ret) ret_accept = rl[2];
        set_req();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hostq.delete();
        req_valid = 0; flush_req = 0; ret_accept = 0; ret_flush = 0; out_stall = 0;
        rl = '0;
        for (int k = 0; k < 2; k++) m_reset(k);
        step(); step();
        reset = 1'b0;
    endtask

    function automatic int n_issue(input int k, input int a, input int b);
        int n = 0;
        for (int c = a; c < b; c++) if (ob_v[k][c]) n++;
        return n;
    endfunction

    function automatic int n_done(input int k, input int a, input int b);
        int n = 0;
        for (int c = a; c < b; c++) if (ob_dn[k][c]) n++;
        return n;
    endfunction

    function automatic int peak_inf(input int k, input int a, input int b);
        int p = 0;
        for (int c = a; c < b; c++) if (int'(ob_inf[k][c]) > p) p = int'(ob_inf[k][c]);
        return p;
    endfunction

    task automatic chk_issued(input string tag, input int k, input int a, input int b, input int n,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        logic [31:0] got [$];
        logic [31:0] ex [3];
        ex[0] = e0; ex[1] = e1; ex[2] = e2;
        for (int c = a; c < b; c++) if (ob_v[k][c]) got.push_back(ob_d[k][c]);
        chk({tag, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++) chk($sformatf("%s_tok%0d", tag, i), got[i], ex[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t0;
        reset = 1'b1;
        req_valid = 0; req_data = '0; flush_req = 0; out_stall = 0; ret_accept = 0; ret_flush = 0;
        for (int k = 0; k < 2; k++) m_reset(k);
        #1;
        step(); step();
        reset = 1'b0;

        // three back-to-back tokens with returns looped three cycles later
        auto_ret = 1;
        hostq = '{32'h11, 32'h22, 32'h33}; set_req();
        t = cyc;
        repeat (12) step();
        chk_issued("s1", 0, t, cyc, 3, 32'h11, 32'h22, 32'h33);
        chk("s1_consec", 32'(ob_v[0][t+1] & ob_v[0][t+2] & ob_v[0][t+3]), 1);
        chk("s1_peak", 32'(peak_inf(0, t, cyc)), 3);
        chk("s1_final_inflight", 32'(ob_inf[0][cyc-1]), 0);
        auto_ret = 0;

        // backpressure holds a token without loss
        do_reset();
        out_stall = 1;
        hostq = '{32'hA5A5A5A5}; set_req();
        t = cyc;
        repeat (6) step();
        out_stall = 0;
        repeat (4) step();
        chk("s2_no_valid_stalled", 32'(n_issue(0, t, t + 6)), 0);
        chk("s2_ready_low", 32'(ob_rdy[0][t+1] | ob_rdy[0][t+3] | ob_rdy[0][t+5]), 0);
        chk("s2_issue_after", 32'(ob_v[0][t+6]), 1);
        chk_issued("s2", 0, t, cyc, 1, 32'hA5A5A5A5, 0, 0);

        // credit cap of two
        do_reset();
        drv = 1;
        hostq = '{32'h1, 32'h2, 32'h3, 32'h4}; set_req();
        t = cyc;
        repeat (8) step();
        chk_issued("s3_cap", 1, t, cyc, 2, 32'h1, 32'h2, 0);
        chk("s3_inflight", 32'(ob_inf[1][cyc-1]), 2);
        chk("s3_ready_low", 32'(ob_rdy[1][cyc-1]), 0);
        ret_accept = 1; step(); ret_accept = 0;
        repeat (3) step();
        chk_issued("s3_after_ret", 1, t, cyc, 3, 32'h1, 32'h2, 32'h3);
        drv = 0;

        // flush with four in flight, marker returns after the head latency
        do_reset();
        hostq = '{32'hB0, 32'hB1, 32'hB2, 32'hB3}; set_req();
        repeat (7) step();
        hostq.push_back(32'hB4); flush_req = 1; set_req();
        t0 = cyc;
        step();
        flush_req = 0;
        t = cyc;
        repeat (HEAD_FLUSH_LAT) step();
        ret_flush = 1; step(); ret_flush = 0;
        repeat (3) step();
        chk("s4_inflight_at_req", 32'(ob_inf[0][t0]), 4);
        chk("s4_flush_pulse", 32'({ob_fl[0][t0], ob_fl[0][t], ob_fl[0][t+1]}), 32'b010);
        chk("s4_no_valid", 32'(n_issue(0, t0, t + 4)), 0);
        chk("s4_done_timing", 32'({ob_dn[0][t+3], ob_dn[0][t+4], ob_dn[0][t+5]}), 32'b010);
        chk("s4_inflight_after", 32'(ob_inf[0][t+4]), 0);
        chk("s4_err", 32'(ob_err[0][t+5]), 0);
        chk_issued("s4_resume", 0, t, cyc, 1, 32'hB4, 0, 0);

        // flush marker never returns
        flush_req = 1; step(); flush_req = 0;
        t = cyc;
        repeat (20) step();
        chk("s5_no_early_done", 32'(n_done(0, t, t + TMO + 1)), 0);
        chk("s5_done_timeout", 32'(ob_dn[0][t+TMO+1]), 1);
        chk("s5_err_before", 32'(ob_err[0][t+TMO]), 0);
        chk("s5_err_sticky", 32'(ob_err[0][cyc-1]), 1);
        hostq.push_back(32'hC1); set_req();
        t = cyc;
        repeat (3) step();
        chk_issued("s5_resume", 0, t, cyc, 1, 32'hC1, 0, 0);

        // reset lands in the middle of a flush wait
        flush_req = 1; step(); flush_req = 0;
        repeat (3) step();
        t0 = cyc;
        do_reset();
        hostq = '{32'hD1}; set_req();
        t = cyc;
        repeat (4) step();
        chk("s6_no_done", 32'(n_done(0, t0, cyc)), 0);
        chk("s6_err_clear", 32'(ob_err[0][t]), 0);
        chk("s6_ready_after", 32'(ob_rdy[0][t]), 1);
        chk_issued("s6_issue", 0, t, cyc, 1, 32'hD1, 0, 0);

        // randomized traffic
        do_reset();
        rand_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            out_stall  = ($urandom_range(9) < 3);
            ret_accept = ($urandom_range(9) < 4);
            flush_req  = ($urandom_range(49) == 0);
            ret_flush  = ($urandom_range(9) == 0);
            if (hostq.size() < 2 && $urandom_range(3) != 0) hostq.push_back($urandom);
            set_req();
            if ($urandom_range(499) == 0) do_reset();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
